// File: rtl/rect_fill_if.sv
// rtl/rect_fill_if.sv - requester/VGA bundle shared by the rectangle fill arbiter
//
// Ports (grouped signals):
//   req          per-requester request level
//   rect_x/y/w/h packed rectangle descriptors, slice i belongs to requester i
//   rect_colour  packed fill colour
//   gnt          one-hot grant, held through the DONE cycle
//   done         one-cycle completion pulse to the granted requester
//   busy         arbiter not idle
//   vga_*        pixel write port towards the VGA adapter
interface rect_fill_if #(
    parameter int NREQ = 3
);
    logic [NREQ-1:0]   req;
    logic [8*NREQ-1:0] rect_x;
    logic [7*NREQ-1:0] rect_y;
    logic [8*NREQ-1:0] rect_w;
    logic [7*NREQ-1:0] rect_h;
    logic [3*NREQ-1:0] rect_colour;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   done;
    logic              busy;
    logic [7:0]        vga_x;
    logic [6:0]        vga_y;
    logic [2:0]        vga_colour;
    logic              vga_plot;

    modport master (
        output req, rect_x, rect_y, rect_w, rect_h, rect_colour,
        input  gnt, done, busy, vga_x, vga_y, vga_colour, vga_plot
    );

    modport slave (
        input  req, rect_x, rect_y, rect_w, rect_h, rect_colour,
        output gnt, done, busy, vga_x, vga_y, vga_colour, vga_plot
    );
endinterface

// File: rtl/rect_fill_arbiter.sv
// rtl/rect_fill_arbiter.sv - round-robin owner of the VGA write port, fills one rectangle pixel per clock
//
// Ports:
//   clock  system clock, rising edge
//   reset  asynchronous active-low reset
//   bus    rect_fill_if slave: requests/descriptors in, grant/done/busy and VGA pixel port out
module rect_fill_arbiter #(
    parameter int NREQ = 3,
    parameter int XMAX = 160,
    parameter int YMAX = 120
) (
    input  logic        clock,
    input  logic        reset,
    rect_fill_if.slave  bus
);
    localparam int IW = (NREQ <= 2) ? 1 : $clog2(NREQ);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state;
    state_t          state_next;

    logic [IW-1:0]   last_ptr;
    logic [IW-1:0]   win_idx;
    logic [IW-1:0]   pick_idx;
    logic            pick_valid;

    // Descriptor latched at grant; rect_* inputs are ignored during a fill.
    logic [7:0]      x0;
    logic [6:0]      y0;
    logic [7:0]      w;
    logic [6:0]      h;
    logic [2:0]      col;
    logic [7:0]      cx;
    logic [6:0]      cy;

    logic [NREQ-1:0] gnt_q;
    logic [NREQ-1:0] done_q;
    logic [7:0]      vx;
    logic [6:0]      vy;
    logic [2:0]      vc;
    logic            vp;

    logic [7:0]      sel_x;
    logic [6:0]      sel_y;
    logic [7:0]      sel_w;
    logic [6:0]      sel_h;
    logic [2:0]      sel_c;
    logic            sel_empty;

    logic            col_end;
    logic            row_end;
    logic [7:0]      ncx;
    logic [6:0]      ncy;
    logic [7:0]      base_x;
    logic [6:0]      base_y;
    logic [7:0]      pix_cx;
    logic [6:0]      pix_cy;
    logic [8:0]      sum_x;
    logic [7:0]      sum_y;
    logic            plot_ok;

    // Round-robin search starting just after the last grant. Scanning from the
    // far end and overwriting leaves the nearest requesting index as winner.
    always_comb begin
        int j;
        pick_valid = 1'b0;
        pick_idx   = '0;
        j          = 0;
        for (int k = NREQ; k >= 1; k--) begin
            j = int'(last_ptr) + k;
            if (j >= NREQ) begin
                j = j - NREQ;
            end
            if (bus.req[j]) begin
                pick_valid = 1'b1;
                pick_idx   = IW'(j);
            end
        end
    end

    assign sel_x     = bus.rect_x[8*pick_idx +: 8];
    assign sel_y     = bus.rect_y[7*pick_idx +: 7];
    assign sel_w     = bus.rect_w[8*pick_idx +: 8];
    assign sel_h     = bus.rect_h[7*pick_idx +: 7];
    assign sel_c     = bus.rect_colour[3*pick_idx +: 3];
    assign sel_empty = (sel_w == 8'd0) || (sel_h == 7'd0);

    assign col_end = (cx == w - 8'd1);
    assign row_end = (cy == h - 7'd1);
    assign ncx     = col_end ? 8'd0 : cx + 8'd1;
    assign ncy     = col_end ? cy + 7'd1 : cy;

    // The pixel registered at the next edge: the origin when granting from
    // IDLE, otherwise the successor of the current pixel.
    always_comb begin
        base_x = x0;
        base_y = y0;
        pix_cx = ncx;
        pix_cy = ncy;
        if (state == IDLE) begin
            base_x = sel_x;
            base_y = sel_y;
            pix_cx = 8'd0;
            pix_cy = 7'd0;
        end
    end

    // Sums are one bit wider than the port so off-screen pixels are detected
    // instead of wrapping onto the visible area.
    assign sum_x   = {1'b0, base_x} + {1'b0, pix_cx};
    assign sum_y   = {1'b0, base_y} + {1'b0, pix_cy};
    assign plot_ok = (32'(sum_x) < XMAX) && (32'(sum_y) < YMAX);

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (pick_valid) begin
                    state_next = sel_empty ? DONE : FILL;
                end
            end
            FILL: begin
                if (col_end && row_end) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last_ptr <= IW'(NREQ - 1);
            win_idx  <= '0;
            x0       <= '0;
            y0       <= '0;
            w        <= '0;
            h        <= '0;
            col      <= '0;
            cx       <= '0;
            cy       <= '0;
            gnt_q    <= '0;
            done_q   <= '0;
            vx       <= '0;
            vy       <= '0;
            vc       <= '0;
            vp       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        gnt_q   <= NREQ'(1) << pick_idx;
                        win_idx <= pick_idx;
                        x0      <= sel_x;
                        y0      <= sel_y;
                        w       <= sel_w;
                        h       <= sel_h;
                        col     <= sel_c;
                        cx      <= 8'd0;
                        cy      <= 7'd0;
                        if (sel_empty) begin
                            done_q <= NREQ'(1) << pick_idx;
                        end else begin
                            vx <= sum_x[7:0];
                            vy <= sum_y[6:0];
                            vc <= sel_c;
                            vp <= plot_ok;
                        end
                    end
                end
                FILL: begin
                    if (col_end && row_end) begin
                        vp     <= 1'b0;
                        done_q <= NREQ'(1) << win_idx;
                    end else begin
                        cx <= ncx;
                        cy <= ncy;
                        vx <= sum_x[7:0];
                        vy <= sum_y[6:0];
                        vc <= col;
                        vp <= plot_ok;
                    end
                end
                DONE: begin
                    done_q   <= '0;
                    gnt_q    <= '0;
                    last_ptr <= win_idx;
                end
                default: begin
                    gnt_q  <= '0;
                    done_q <= '0;
                    vp     <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gnt        = gnt_q;
    assign bus.done       = done_q;
    assign bus.busy       = (state != IDLE);
    assign bus.vga_x      = vx;
    assign bus.vga_y      = vy;
    assign bus.vga_colour = vc;
    assign bus.vga_plot   = vp;
endmodule

// File: tb/tb_rect_fill_arbiter.sv
// tb/tb_rect_fill_arbiter.sv - self-checking bench for rect_fill_arbiter
module tb_rect_fill_arbiter;
    localparam int NREQ = 3;
    localparam int XMAX = 160;
    localparam int YMAX = 120;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    rect_fill_if #(.NREQ(NREQ)) bus ();

    rect_fill_arbiter #(.NREQ(NREQ), .XMAX(XMAX), .YMAX(YMAX)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference model state: last granted requester and held pixel outputs.
    int m_ptr;
    int m_lx, m_ly, m_lc;
    int tx[NREQ], ty[NREQ], tw[NREQ], th[NREQ], tc[NREQ];

    logic [NREQ-1:0] o_gnt[128], o_done[128], e_gnt[128], e_done[128];
    logic            o_busy[128], o_plot[128], e_busy[128], e_plot[128];
    logic [7:0]      o_x[128], e_x[128];
    logic [6:0]      o_y[128], e_y[128];
    logic [2:0]      o_c[128], e_c[128];

    task automatic set_rect(input int i, input int x, input int y, input int w, input int h, input int c);
        tx[i] = x; ty[i] = y; tw[i] = w; th[i] = h; tc[i] = c;
        bus.rect_x[8*i +: 8]      = 8'(x);
        bus.rect_y[7*i +: 7]      = 7'(y);
        bus.rect_w[8*i +: 8]      = 8'(w);
        bus.rect_h[7*i +: 7]      = 7'(h);
        bus.rect_colour[3*i +: 3] = 3'(c);
    endtask

    function automatic int rr_pick(input logic [NREQ-1:0] m, input int ptr);
        for (int k = 1; k <= NREQ; k++) begin
            if (m[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
        end
        return -1;
    endfunction

    // Expected per-cycle trace of one fill, starting in the cycle after the grant edge.
    task automatic model_fill(input int win, output int len);
        int n;
        int ex, ey;
        n = tw[win] * th[win];
        for (int p = 0; p < n; p++) begin
            ex = tx[win] + p % tw[win];
            ey = ty[win] + p / tw[win];
            e_gnt[p]  = NREQ'(1) << win;
            e_done[p] = '0;
            e_busy[p] = 1'b1;
            e_plot[p] = (ex < XMAX) && (ey < YMAX);
            e_x[p]    = 8'(ex % 256);
            e_y[p]    = 7'(ey % 128);
            e_c[p]    = 3'(tc[win]);
            m_lx = ex % 256; m_ly = ey % 128; m_lc = tc[win];
        end
        e_gnt[n] = NREQ'(1) << win; e_done[n] = NREQ'(1) << win; e_busy[n] = 1'b1; e_plot[n] = 1'b0;
        e_gnt[n+1] = '0; e_done[n+1] = '0; e_busy[n+1] = 1'b0; e_plot[n+1] = 1'b0;
        for (int i = n; i <= n + 1; i++) begin
            e_x[i] = 8'(m_lx); e_y[i] = 7'(m_ly); e_c[i] = 3'(m_lc);
        end
        m_ptr = win;
        len = n + 2;
    endtask

    // Waits for the grant edge, then records n cycles sampled on the falling edge.
    task automatic collect(input int n, input logic [NREQ-1:0] clr, input bit scramble);
        @(posedge clock);
        #1;
        bus.req = bus.req & ~clr;
        if (scramble) begin
            bus.rect_x = $urandom; bus.rect_y = $urandom; bus.rect_w = $urandom;
            bus.rect_h = $urandom; bus.rect_colour = $urandom;
        end
        for (int i = 0; i < n; i++) begin
            if (i > 0) @(posedge clock);
            @(negedge clock);
            o_gnt[i] = bus.gnt; o_done[i] = bus.done; o_busy[i] = bus.busy; o_plot[i] = bus.vga_plot;
            o_x[i] = bus.vga_x; o_y[i] = bus.vga_y; o_c[i] = bus.vga_colour;
        end
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if ({bus.gnt, bus.done, bus.busy, bus.vga_plot, bus.vga_x, bus.vga_y, bus.vga_colour} !== '0) begin
            errors++;
            $display("FAIL reset_values: got gnt=%b done=%b busy=%b plot=%b x=%0d y=%0d c=%0d want all 0",
                     bus.gnt, bus.done, bus.busy, bus.vga_plot, bus.vga_x, bus.vga_y, bus.vga_colour);
        end
        @(negedge clock);
        reset = 1'b1;
        m_ptr = NREQ - 1; m_lx = 0; m_ly = 0; m_lc = 0;
    endtask

    task automatic test_single;
        int win, len;
        @(posedge clock); #1;
        set_rect(0, 10, 5, 3, 2, 3'b100);
        bus.req = 3'b001;
        win = rr_pick(bus.req, m_ptr);
        model_fill(win, len);
        collect(len, '1, 1'b0);
        for (int i = 0; i < len; i++) begin
            checks++;
            if ({o_gnt[i], o_done[i], o_busy[i], o_plot[i]} !== {e_gnt[i], e_done[i], e_busy[i], e_plot[i]}) begin
                errors++;
                $display("FAIL single ctl[%0d]: got gnt=%b done=%b busy=%b plot=%b want %b %b %b %b", i,
                         o_gnt[i], o_done[i], o_busy[i], o_plot[i], e_gnt[i], e_done[i], e_busy[i], e_plot[i]);
            end
            checks++;
            if ({o_x[i], o_y[i], o_c[i]} !== {e_x[i], e_y[i], e_c[i]}) begin
                errors++;
                $display("FAIL single pix[%0d]: got (%0d,%0d,%0d) want (%0d,%0d,%0d)", i,
                         o_x[i], o_y[i], o_c[i], e_x[i], e_y[i], e_c[i]);
            end
        end
    endtask

    task automatic test_round_robin;
        int p;
        int wseq[4];
        for (int i = 0; i < NREQ; i++) set_rect(i, 5 * i + 1, 3 * i + 2, 1, 1, i + 1);
        p = m_ptr;
        for (int g = 0; g < 4; g++) begin
            wseq[g] = rr_pick(3'b111, p);
            p = wseq[g];
        end
        @(posedge clock); #1;
        bus.req = 3'b111;
        collect(11, '0, 1'b0);
        @(posedge clock); #1;
        bus.req = '0;
        for (int g = 0; g < 4; g++) begin
            checks++;
            if (o_gnt[3*g] !== (NREQ'(1) << wseq[g]) || o_plot[3*g] !== 1'b1 || o_x[3*g] !== 8'(tx[wseq[g]])) begin
                errors++;
                $display("FAIL rr_grant[%0d]: got gnt=%b plot=%b x=%0d want gnt=%b plot=1 x=%0d", g,
                         o_gnt[3*g], o_plot[3*g], o_x[3*g], NREQ'(1) << wseq[g], tx[wseq[g]]);
            end
            checks++;
            if (o_done[3*g+1] !== (NREQ'(1) << wseq[g])) begin
                errors++;
                $display("FAIL rr_done[%0d]: got %b want %b", g, o_done[3*g+1], NREQ'(1) << wseq[g]);
            end
            if (g < 3) begin
                checks++;
                if (o_gnt[3*g+2] !== '0 || o_busy[3*g+2] !== 1'b0) begin
                    errors++;
                    $display("FAIL rr_idle[%0d]: got gnt=%b busy=%b want 0 0", g, o_gnt[3*g+2], o_busy[3*g+2]);
                end
            end
        end
        m_ptr = p;
        m_lx = tx[p]; m_ly = ty[p]; m_lc = tc[p];
        repeat (3) @(posedge clock);
    endtask

    task automatic test_one(input string name, input int idx, input int x, input int y,
                            input int w, input int h, input int c, input bit scramble);
        int win, len;
        @(posedge clock); #1;
        set_rect(idx, x, y, w, h, c);
        bus.req = NREQ'(1) << idx;
        win = rr_pick(bus.req, m_ptr);
        model_fill(win, len);
        collect(len, '1, scramble);
        for (int i = 0; i < len; i++) begin
            checks++;
            if ({o_gnt[i], o_done[i], o_busy[i], o_plot[i]} !== {e_gnt[i], e_done[i], e_busy[i], e_plot[i]}) begin
                errors++;
                $display("FAIL %s ctl[%0d]: got gnt=%b done=%b busy=%b plot=%b want %b %b %b %b", name, i,
                         o_gnt[i], o_done[i], o_busy[i], o_plot[i], e_gnt[i], e_done[i], e_busy[i], e_plot[i]);
            end
            checks++;
            if ({o_x[i], o_y[i], o_c[i]} !== {e_x[i], e_y[i], e_c[i]}) begin
                errors++;
                $display("FAIL %s pix[%0d]: got (%0d,%0d,%0d) want (%0d,%0d,%0d)", name, i,
                         o_x[i], o_y[i], o_c[i], e_x[i], e_y[i], e_c[i]);
            end
        end
    endtask

    task automatic test_clipping;
        test_one("clip", 1, 158, 119, 4, 2, 5, 1'b0);
    endtask

    task automatic test_empty;
        test_one("empty", 2, 40, 40, 0, 5, 2, 1'b0);
    endtask

    task automatic test_stability;
        test_one("stable", 0, 20, 30, 4, 3, 6, 1'b1);
    endtask

    task automatic test_random;
        int win, len;
        for (int it = 0; it < 24; it++) begin
            @(posedge clock); #1;
            for (int i = 0; i < NREQ; i++) begin
                set_rect(i, ($urandom_range(0, 1) != 0) ? $urandom_range(150, 255) : $urandom_range(0, 149),
                         ($urandom_range(0, 1) != 0) ? $urandom_range(110, 127) : $urandom_range(0, 109),
                         $urandom_range(0, 4), $urandom_range(0, 3), $urandom_range(0, 7));
            end
            bus.req = NREQ'($urandom_range(1, 7));
            win = rr_pick(bus.req, m_ptr);
            model_fill(win, len);
            collect(len, '1, 1'b1);
            for (int i = 0; i < len; i++) begin
                checks++;
                if ({o_gnt[i], o_done[i], o_busy[i], o_plot[i]} !== {e_gnt[i], e_done[i], e_busy[i], e_plot[i]}) begin
                    errors++;
                    $display("FAIL random%0d ctl[%0d]: got gnt=%b done=%b busy=%b plot=%b want %b %b %b %b", it, i,
                             o_gnt[i], o_done[i], o_busy[i], o_plot[i], e_gnt[i], e_done[i], e_busy[i], e_plot[i]);
                end
                checks++;
                if ({o_x[i], o_y[i], o_c[i]} !== {e_x[i], e_y[i], e_c[i]}) begin
                    errors++;
                    $display("FAIL random%0d pix[%0d]: got (%0d,%0d,%0d) want (%0d,%0d,%0d)", it, i,
                             o_x[i], o_y[i], o_c[i], e_x[i], e_y[i], e_c[i]);
                end
            end
        end
    endtask

    task automatic test_async_reset;
        int win, len;
        @(posedge clock); #1;
        set_rect(0, 0, 0, 8, 8, 7);
        bus.req = 3'b001;
        @(posedge clock); #1;
        bus.req = '0;
        @(posedge clock);
        @(negedge clock);
        checks++;
        if (bus.busy !== 1'b1 || bus.vga_plot !== 1'b1 || bus.gnt !== 3'b001) begin
            errors++;
            $display("FAIL areset_pre: got busy=%b plot=%b gnt=%b want 1 1 001", bus.busy, bus.vga_plot, bus.gnt);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if ({bus.gnt, bus.done, bus.busy, bus.vga_plot, bus.vga_x, bus.vga_y, bus.vga_colour} !== '0) begin
            errors++;
            $display("FAIL areset_now: got gnt=%b done=%b busy=%b plot=%b x=%0d want all 0",
                     bus.gnt, bus.done, bus.busy, bus.vga_plot, bus.vga_x);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            checks++;
            if (bus.done !== '0 || bus.busy !== 1'b0) begin
                errors++;
                $display("FAIL areset_hold[%0d]: got done=%b busy=%b want 0 0", i, bus.done, bus.busy);
            end
        end
        reset = 1'b1;
        m_ptr = NREQ - 1; m_lx = 0; m_ly = 0; m_lc = 0;
        @(posedge clock); #1;
        set_rect(0, 50, 60, 1, 1, 3);
        set_rect(2, 70, 80, 1, 1, 4);
        bus.req = 3'b101;
        win = rr_pick(bus.req, m_ptr);
        model_fill(win, len);
        collect(len, '1, 1'b0);
        for (int i = 0; i < len; i++) begin
            checks++;
            if ({o_gnt[i], o_done[i], o_busy[i], o_plot[i], o_x[i], o_y[i]} !==
                {e_gnt[i], e_done[i], e_busy[i], e_plot[i], e_x[i], e_y[i]}) begin
                errors++;
                $display("FAIL areset_after[%0d]: got gnt=%b done=%b plot=%b (%0d,%0d) want %b %b %b (%0d,%0d)", i,
                         o_gnt[i], o_done[i], o_plot[i], o_x[i], o_y[i], e_gnt[i], e_done[i], e_plot[i], e_x[i], e_y[i]);
            end
        end
    endtask

    initial begin
        bus.req = '0;
        bus.rect_x = '0; bus.rect_y = '0; bus.rect_w = '0; bus.rect_h = '0; bus.rect_colour = '0;
        for (int i = 0; i < NREQ; i++) begin
            tx[i] = 0; ty[i] = 0; tw[i] = 0; th[i] = 0; tc[i] = 0;
        end
        test_reset;
        test_single;
        test_round_robin;
        test_clipping;
        test_empty;
        test_stability;
        test_random;
        test_async_reset;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rect_fill_arbiter.md
# rect_fill_arbiter

Shares the single VGA adapter write port (x, y, colour, plot) among several rectangle-drawing requesters: background draw, car draw and car erase in the race game. Each requester presents a rectangle descriptor with a request. The block grants one requester at a time in round-robin order, then scans the rectangle one pixel per clock onto the VGA port. It replaces the per-state plot muxing in the game controller with a single sequenced owner of the frame buffer write path.

## Interface
- NREQ, 3, number of requesters (2..8)
- XMAX, 160, screen width; pixels with x >= XMAX are not plotted
- YMAX, 120, screen height; pixels with y >= YMAX are not plotted
- clock  in  1  system clock; all state changes on rising edge
- reset  in  1  asynchronous, active-low; clears all state immediately
- req  in  NREQ  per-requester request level
- rect_x  in  8*NREQ  packed left-edge x; slice i = [8i+7:8i]
- rect_y  in  7*NREQ  packed top-edge y
- rect_w  in  8*NREQ  packed width in pixels; 0 means empty
- rect_h  in  7*NREQ  packed height in pixels; 0 means empty
- rect_colour  in  3*NREQ  packed fill colour
- gnt  out  NREQ  one-hot grant, held for the whole fill including the DONE cycle
- done  out  NREQ  one-cycle completion pulse to the granted requester
- busy  out  1  high whenever state != IDLE
- vga_x  out  8  pixel x to VGA adapter
- vga_y  out  7  pixel y to VGA adapter
- vga_colour  out  3  pixel colour
- vga_plot  out  1  write enable to VGA adapter

## Operation
- States: IDLE, FILL, DONE.
- IDLE: if any req bit is high, choose a winner by round-robin and register it into gnt. Latch its x0, y0, w, h and colour. Clear the column counter cx and row counter cy. Go to FILL, or go directly to DONE if w==0 or h==0. With no request, stay in IDLE.
- Round-robin: after granting requester i, the search order is i+1, i+2, …, NREQ-1, 0, …, i. After reset the last-granted pointer is NREQ-1, so requester 0 has top priority.
- FILL: each cycle presents pixel (x0+cx, y0+cy) with the latched colour.
  - Sums are computed 9 bits (x) and 8 bits (y) wide. vga_plot=1 only if x0+cx < XMAX and y0+cy < YMAX.
  - Off-screen pixels still consume their cycle, with vga_plot=0. vga_x/vga_y carry the truncated sum.
  - cx increments each cycle. When cx==w-1, cx clears and cy increments. When cx==w-1 and cy==h-1, go to DONE.
- DONE: done[winner]=1 for exactly one cycle, gnt still held. Update the last-granted pointer and go to IDLE. gnt clears on entry to IDLE.
- The descriptor is captured only at grant. Later changes to rect_* or req from any requester do not affect an active fill.
- Deasserting req mid-fill does not abort the fill.
- A requester must drop req in the cycle after done. If req is still high in IDLE, it is treated as a new request.
- Outside FILL: vga_plot=0; vga_x, vga_y and vga_colour hold their last values.

## Timing
- Reset values: gnt=0, done=0, busy=0, vga_plot=0, vga_x=0, vga_y=0, vga_colour=0, state=IDLE, last-granted pointer=NREQ-1.
- Reset asserted mid-fill: the fill is abandoned with no done pulse. Outputs take reset values asynchronously.
- Timeline for req sampled high in IDLE at edge k:
  - gnt and busy are high from cycle k+1.
  - The first pixel (x0, y0) is presented in cycle k+1.
  - The last pixel is presented in cycle k+w*h.
  - done is high in cycle k+w*h+1.
  - The block is back in IDLE in cycle k+w*h+2.
- Empty rectangle: done in cycle k+1, IDLE in cycle k+2.
- Back-to-back requests: minimum gap between the done of one grant and the first pixel of the next grant is 1 cycle (the IDLE cycle).
- Throughput: exactly one pixel per clock in FILL. There is no backpressure from the VGA adapter.

## Test plan
- Single request: req0, x0=10, y0=5, w=3, h=2, colour=3'b100.
  - Six plots: (10,5), (11,5), (12,5), (10,6), (11,6), (12,6), in cycles 1–6.
  - done[0] in cycle 7; gnt=0 and busy=0 in cycle 8.
- Round-robin: req=3'b111 held continuously, all w=h=1. Grants go 0, 1, 2, 0 in that order, each grant 3 cycles apart.
- Clipping: x0=158, y0=119, w=4, h=2.
  - 8 FILL cycles.
  - vga_plot high only for (158,119) and (159,119).
  - done follows the 8th cycle.
- Empty rectangle: w=0, h=5. No vga_plot pulse; done one cycle after grant.
- Descriptor stability: change rect_x and drop req0 during a fill. All pixels use the latched x0, and the fill completes with done.
- Async reset: assert reset low mid-fill, between clock edges.
  - gnt, busy and vga_plot go 0 immediately, with no done pulse.
  - After release, req2 and req0 asserted together: req0 is granted first.
